// File: rtl/timer_unit.sv
// ---------------------------------------------------------------------------
// timer_unit
//
// Prescaled up-counter timer peripheral driven by timer-class instructions.
// A prescaler divides the clock by (PSC+1); every prescaler tick advances the
// counter, which wraps to zero after reaching the auto-reload value (ARR).
// Each wrap produces a one-cycle update event and sets a sticky irq flag.
// PSC and ARR are double-buffered: while running, writes land in a preload
// register and become active at the next update event; while stopped, writes
// take effect immediately.
//
// Ports
//   clk         system clock (all state on rising edge)
//   reset       synchronous, active-high reset
//   timer_en    run enable from the control unit (level)
//   cmd_valid   one-cycle strobe: current instruction is a timer write
//   cmd_code    alu_cntrl timer code (PSC_I/PSC_REG/ARR_I/ARR_REG)
//   cmd_data    operand (immediate or rs1 value), upper bits truncated
//   irq_clr     one-cycle strobe clearing irq
//   cnt         current counter value
//   psc_q       active prescaler value
//   arr_q       active auto-reload value
//   update_evt  one-cycle pulse following a counter wrap
//   irq         sticky update flag
//   running     registered copy of timer_en
// ---------------------------------------------------------------------------
module timer_unit #(
    parameter int unsigned           CNT_WIDTH = 16,
    parameter int unsigned           PSC_WIDTH = 16,
    parameter logic [CNT_WIDTH-1:0]  ARR_RESET = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 timer_en,
    input  logic                 cmd_valid,
    input  logic [5:0]           cmd_code,
    input  logic [31:0]          cmd_data,
    input  logic                 irq_clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [PSC_WIDTH-1:0] psc_q,
    output logic [CNT_WIDTH-1:0] arr_q,
    output logic                 update_evt,
    output logic                 irq,
    output logic                 running
);

    localparam logic [5:0] CODE_PSC_I   = 6'b100001;
    localparam logic [5:0] CODE_ARR_I   = 6'b100010;
    localparam logic [5:0] CODE_PSC_REG = 6'b100011;
    localparam logic [5:0] CODE_ARR_REG = 6'b100100;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    run_state_t state;
    run_state_t state_next;

    logic [PSC_WIDTH-1:0] psc_cnt;
    logic [PSC_WIDTH-1:0] psc_act;
    logic [PSC_WIDTH-1:0] psc_pre;
    logic [CNT_WIDTH-1:0] arr_act;
    logic [CNT_WIDTH-1:0] arr_pre;

    logic psc_wr;
    logic arr_wr;
    logic tick;
    logic wrap;

    // ------------------------------------------------------------------
    // Run-state FSM: state register / next-state / output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STOPPED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = STOPPED;
        if (timer_en) begin
            state_next = RUNNING;
        end
    end

    always_comb begin
        running = (state == RUNNING);
    end

    // ------------------------------------------------------------------
    // Command decode and count qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        psc_wr = cmd_valid && ((cmd_code == CODE_PSC_I) || (cmd_code == CODE_PSC_REG));
        arr_wr = cmd_valid && ((cmd_code == CODE_ARR_I) || (cmd_code == CODE_ARR_REG));
        // Counting is gated by the registered run state, so enabling costs
        // one cycle before the first prescaler step.
        tick   = running && (psc_cnt == psc_act);
        wrap   = tick && (cnt == arr_act);
    end

    // ------------------------------------------------------------------
    // Prescaler, counter, event and irq
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_cnt    <= '0;
            cnt        <= '0;
            update_evt <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (running) begin
                psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
            end
            // An active ARR below cnt lets cnt run on and roll over naturally
            // at all-ones without raising an event.
            if (tick) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
            update_evt <= wrap;
            // Set has priority over a coincident clear.
            if (update_evt) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Preload / active registers
    // A write coinciding with a wrap: active takes the old preload value
    // (right-hand side sampled before the edge), the write lands in preload.
    // Wrap never happens while stopped, so the direct write cannot collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_pre <= '0;
            psc_act <= '0;
            arr_pre <= ARR_RESET;
            arr_act <= ARR_RESET;
        end else begin
            if (wrap) begin
                psc_act <= psc_pre;
                arr_act <= arr_pre;
            end
            if (psc_wr) begin
                psc_pre <= cmd_data[PSC_WIDTH-1:0];
                if (!running) begin
                    psc_act <= cmd_data[PSC_WIDTH-1:0];
                end
            end
            if (arr_wr) begin
                arr_pre <= cmd_data[CNT_WIDTH-1:0];
                if (!running) begin
                    arr_act <= cmd_data[CNT_WIDTH-1:0];
                end
            end
        end
    end

    assign psc_q = psc_act;
    assign arr_q = arr_act;

endmodule
